// File: rtl/rle_sprite_loader.sv
// rle_sprite_loader
// Decodes a run-length-encoded sprite image from the sprite ROM into the frame RAM.
// Each ROM byte is {run-1, palette index}. The loader writes one pixel per cycle
// from a latched base address and stops after exactly PIX_COUNT pixels.
// Optional build macro: SPRITE_LOADER_TRANSPARENT_SKIP_EN
//   defined   -> runs of index 0 advance the pixel count without writing RAM
//   undefined -> index 0 is written like any other index
//
// state   | meaning
// S_IDLE  | waiting for start; bases latched on an accepted start
// S_FETCH | rom_addr presented, ROM byte arrives next cycle
// S_LATCH | ROM byte captured, run clamped to the remaining pixels
// S_RUN   | one pixel write per cycle until the run is exhausted
// S_DONE  | one-cycle done pulse, then back to idle
module rle_sprite_loader #(
    parameter int PIX_COUNT = 35344,
    parameter int ROM_AW    = 16,
    parameter int RAM_AW    = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ROM_AW-1:0] rom_base,
    input  logic [RAM_AW-1:0] ram_base,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              we,
    output logic [RAM_AW-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PCW = $clog2(PIX_COUNT + 1);
    // Wide enough for pix_cnt plus a 16-pixel run without overflow.
    localparam int CW  = PCW + 5;
    localparam logic [CW-1:0]  PIX_TOTAL = CW'(PIX_COUNT);
    localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIX_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [RAM_AW-1:0] ram_base_q, ram_base_d;
    logic [PCW-1:0]    pix_cnt, pix_cnt_d;
    logic [3:0]        run_left, run_left_d;
    logic [ROM_AW-1:0] rom_addr_d;
    logic              we_d;
    logic [RAM_AW-1:0] wr_addr_d;
    logic [3:0]        wr_data_d;
    logic              busy_d;
    logic              done_d;
    logic              error_d;

    logic [CW-1:0]     run_raw;
    logic [CW-1:0]     remaining;
    logic [CW-1:0]     run_eff;
    logic [CW-1:0]     run_m1;
    logic [CW-1:0]     pix_after;
    logic              overrun;
    logic              skip;

    // Run-length decode of the current ROM byte, clamped to the pixels still owed.
    always_comb begin
        run_raw   = CW'(rom_data[7:4]) + CW'(1);
        remaining = PIX_TOTAL - CW'(pix_cnt);
        overrun   = (run_raw > remaining);
        run_eff   = overrun ? remaining : run_raw;
        run_m1    = run_eff - CW'(1);
        pix_after = CW'(pix_cnt) + run_eff;
        skip      = 1'b0;
`ifdef SPRITE_LOADER_TRANSPARENT_SKIP_EN
        skip      = (rom_data[3:0] == 4'd0);
`endif
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_d    = state;
        ram_base_d = ram_base_q;
        pix_cnt_d  = pix_cnt;
        run_left_d = run_left;
        rom_addr_d = rom_addr;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        error_d    = error;

        case (state)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d = rom_base;
                    ram_base_d = ram_base;
                    pix_cnt_d  = '0;
                    error_d    = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                rom_addr_d = rom_addr + ROM_AW'(1);
                if (overrun) begin
                    error_d = 1'b1;
                end
                if (skip) begin
                    pix_cnt_d = pix_after[PCW-1:0];
                    state_d   = (pix_after == PIX_TOTAL) ? S_DONE : S_FETCH;
                end else begin
                    we_d       = 1'b1;
                    wr_data_d  = rom_data[3:0];
                    wr_addr_d  = ram_base_q + RAM_AW'(pix_cnt);
                    pix_cnt_d  = pix_cnt + PCW'(1);
                    run_left_d = run_m1[3:0];
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // run_left counts the writes still owed after the one on the bus now.
                if (run_left == 4'd0) begin
                    state_d = (pix_cnt == PIX_LAST) ? S_DONE : S_FETCH;
                end else begin
                    we_d       = 1'b1;
                    wr_addr_d  = ram_base_q + RAM_AW'(pix_cnt);
                    pix_cnt_d  = pix_cnt + PCW'(1);
                    run_left_d = run_left - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State register and registered outputs, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            ram_base_q <= '0;
            pix_cnt    <= '0;
            run_left   <= '0;
            rom_addr   <= '0;
            we         <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            ram_base_q <= ram_base_d;
            pix_cnt    <= pix_cnt_d;
            run_left   <= run_left_d;
            rom_addr   <= rom_addr_d;
            we         <= we_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_rle_sprite_loader.sv
// Testbench for rle_sprite_loader with an 8-pixel image size.
// A synchronous ROM model feeds the DUT; a reference model walks the RLE bytes
// with plain arithmetic and predicts every write (edge, address, index), the
// done edge, the overrun flag and how many ROM bytes get consumed.
module tb_rle_sprite_loader;

    localparam int PIXN = 8;
`ifdef SPRITE_LOADER_TRANSPARENT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] t;
        logic [18:0] a;
        logic [3:0]  d;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rom_base = '0;
    logic [18:0] ram_base = '0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        we;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;

    logic [7:0]  rom_mem [0:255];

    int total = 0;
    int bad = 0;

    wr_t         exp_wr[$];
    wr_t         got_wr[$];
    int          exp_done;
    logic        exp_err;
    logic [15:0] exp_rom_end;
    int          got_done;
    logic        got_err, got_err0, got_busy0;
    logic        got_done_after, got_busy_after, got_aborted;
    logic [15:0] got_rom_end;

    rle_sprite_loader #(.PIX_COUNT(PIXN), .ROM_AW(16), .RAM_AW(19)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .rom_base (rom_base),
        .ram_base (ram_base),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: byte for rom_addr appears one cycle later.
    always @(posedge Clk) rom_data <= rom_mem[rom_addr[7:0]];

    // Reference: times are edges after the accepting edge; each byte costs
    // 2 overhead cycles plus its run, the first write lands 3 edges in.
    task automatic model_image(input logic [15:0] rb, input logic [18:0] wb);
        int pix, t, run;
        logic [7:0]  b;
        logic [3:0]  idx;
        logic [15:0] a;
        wr_t w;
        pix = 0; t = 0; a = rb;
        exp_wr.delete();
        exp_err = 1'b0;
        while (pix < PIXN) begin
            b = rom_mem[a[7:0]];
            a = a + 16'd1;
            run = int'(b[7:4]) + 1;
            idx = b[3:0];
            if (run > PIXN - pix) begin
                run = PIXN - pix;
                exp_err = 1'b1;
            end
            if (SKIP && idx == 4'd0) begin
                pix += run;
                t += 2;
            end else begin
                for (int j = 0; j < run; j++) begin
                    w.t = 32'(t + 3 + j);
                    w.a = wb + 19'(pix);
                    w.d = idx;
                    exp_wr.push_back(w);
                    pix++;
                end
                t += 2 + run;
            end
        end
        exp_done = t + 1;
        exp_rom_end = a;
    endtask

    // Pulse start and record everything the DUT does until done (or abort).
    task automatic run_image(input logic [15:0] rb, input logic [18:0] wb,
                             input int poke_m, input int abort_after);
        wr_t w;
        got_wr.delete();
        got_done = -1;
        got_aborted = 1'b0;
        got_done_after = 1'bx;
        got_busy_after = 1'bx;
        @(negedge Clk);
        rom_base = rb; ram_base = wb; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        got_busy0 = busy;
        got_err0 = error;
        for (int m = 0; m < 400; m++) begin
            if (m > 0) @(negedge Clk);
            if (we) begin
                w.t = 32'(m + 1); w.a = wr_addr; w.d = wr_data;
                got_wr.push_back(w);
                if (abort_after > 0 && got_wr.size() == abort_after) begin
                    Reset_n = 1'b0;
                    got_aborted = 1'b1;
                    break;
                end
            end
            if (done) begin
                got_done = m + 1;
                break;
            end
            if (m == poke_m) begin
                start = 1'b1; rom_base = rb + 16'h0040; ram_base = wb ^ 19'h55555;
            end else if (m == poke_m + 1) begin
                start = 1'b0; rom_base = rb; ram_base = wb;
            end
        end
        start = 1'b0;
        got_err = error;
        got_rom_end = rom_addr;
        if (!got_aborted && got_done >= 0) begin
            @(negedge Clk);
            got_done_after = done;
            got_busy_after = busy;
        end
    endtask

    task automatic test_basic;
        rom_mem[8'h10] = 8'h35; rom_mem[8'h11] = 8'h32; rom_mem[8'h12] = 8'h7A;
        model_image(16'h0010, 19'h00100);
        run_image(16'h0010, 19'h00100, -1, 0);
        total++;
        if (got_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL basic_count: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            total++;
            if (got_wr[i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL basic_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", i,
                         got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (got_wr.size() == 0 || got_wr[0].t !== 32'd3) begin
            bad++; $display("FAIL basic_first_write: got %0d want 3", got_wr.size() ? got_wr[0].t : 0);
        end
        total++;
        if (got_done != exp_done) begin
            bad++; $display("FAIL basic_done: got %0d want %0d", got_done, exp_done);
        end
        total++;
        if (got_err !== 1'b0 || got_busy0 !== 1'b1) begin
            bad++; $display("FAIL basic_flags: got err=%b busy0=%b want 0 1", got_err, got_busy0);
        end
        total++;
        if (got_done_after !== 1'b0 || got_busy_after !== 1'b0) begin
            bad++; $display("FAIL basic_pulse: got done=%b busy=%b want 0 0", got_done_after, got_busy_after);
        end
    endtask

    task automatic test_overrun;
        rom_mem[8'h40] = 8'hF7; rom_mem[8'h41] = 8'h12;
        model_image(16'h0040, 19'h00000);
        run_image(16'h0040, 19'h00000, -1, 0);
        total++;
        if (got_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL overrun_count: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            total++;
            if (got_wr[i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL overrun_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", i,
                         got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (got_err !== 1'b1) begin
            bad++; $display("FAIL overrun_error: got %b want 1", got_err);
        end
        total++;
        if (got_rom_end !== 16'h0041) begin
            bad++; $display("FAIL overrun_rom_bytes: got rom_addr=%h want 0041", got_rom_end);
        end
        total++;
        if (got_done != exp_done) begin
            bad++; $display("FAIL overrun_done: got %0d want %0d", got_done, exp_done);
        end
        repeat (3) @(negedge Clk);
        total++;
        if (error !== 1'b1) begin
            bad++; $display("FAIL overrun_sticky: got %b want 1", error);
        end
    endtask

    task automatic test_reset;
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        total++;
        if ({we, busy, done, error} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got we/busy/done/err=%b want 0000", {we, busy, done, error});
        end
        total++;
        if (rom_addr !== 16'h0 || wr_addr !== 19'h0 || wr_data !== 4'h0) begin
            bad++; $display("FAIL reset_addr: got rom=%h wr=%h data=%h want 0 0 0", rom_addr, wr_addr, wr_data);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_transparent;
        rom_mem[8'h00] = 8'h30; rom_mem[8'h01] = 8'h31;
        model_image(16'h0000, 19'h00000);
        run_image(16'h0000, 19'h00000, -1, 0);
        total++;
        if (got_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL transp_count: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            total++;
            if (got_wr[i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL transp_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", i,
                         got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (got_done != exp_done) begin
            bad++; $display("FAIL transp_done: got %0d want %0d", got_done, exp_done);
        end
    endtask

    task automatic test_abort;
        rom_mem[8'h20] = 8'h35; rom_mem[8'h21] = 8'h32;
        run_image(16'h0020, 19'h00200, -1, 2);
        @(negedge Clk);
        total++;
        if ({we, busy, done} !== 3'b000) begin
            bad++; $display("FAIL abort_stop: got we/busy/done=%b want 000", {we, busy, done});
        end
        total++;
        if (got_wr.size() != 2) begin
            bad++; $display("FAIL abort_writes: got %0d want 2", got_wr.size());
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL abort_no_done: got %b want 0", done);
        end
        model_image(16'h0020, 19'h00200);
        run_image(16'h0020, 19'h00200, -1, 0);
        total++;
        if (got_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL abort_restart_count: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            total++;
            if (got_wr[i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL abort_restart_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", i,
                         got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (got_rom_end !== exp_rom_end || got_done != exp_done) begin
            bad++; $display("FAIL abort_restart_end: got rom=%h done=%0d want rom=%h done=%0d",
                            got_rom_end, got_done, exp_rom_end, exp_done);
        end
    endtask

    task automatic test_wrap;
        rom_mem[8'h30] = 8'h39; rom_mem[8'h31] = 8'h39;
        rom_mem[8'h70] = 8'h0F; rom_mem[8'h71] = 8'h0F;
        model_image(16'h0030, 19'h7FFFE);
        run_image(16'h0030, 19'h7FFFE, 4, 0);
        total++;
        if (got_wr.size() != exp_wr.size()) begin
            bad++; $display("FAIL wrap_count: got %0d want %0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            total++;
            if (got_wr[i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL wrap_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", i,
                         got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (got_wr.size() < 3 || got_wr[2].a !== 19'h00000) begin
            bad++; $display("FAIL wrap_addr: got %h want 00000", got_wr.size() >= 3 ? got_wr[2].a : 19'h7FFFF);
        end
        total++;
        if (got_rom_end !== 16'h0032 || got_done != exp_done) begin
            bad++; $display("FAIL wrap_end: got rom=%h done=%0d want rom=0032 done=%0d",
                            got_rom_end, got_done, exp_done);
        end
    endtask

    task automatic test_random;
        logic [15:0] rb;
        logic [18:0] wb;
        logic [3:0]  hi;
        for (int n = 0; n < 25; n++) begin
            rb = 16'($urandom_range(0, 200));
            wb = 19'($urandom);
            for (int b = 0; b < 8; b++) begin
                hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
                rom_mem[rb[7:0] + 8'(b)] = {hi, 4'($urandom_range(0, 3))};
            end
            model_image(rb, wb);
            run_image(rb, wb, -1, 0);
            total++;
            if (got_wr.size() != exp_wr.size()) begin
                bad++; $display("FAIL rand%0d_count: got %0d want %0d", n, got_wr.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
                total++;
                if (got_wr[i] !== exp_wr[i]) begin
                    bad++;
                    $display("FAIL rand%0d_wr[%0d]: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", n, i,
                             got_wr[i].t, got_wr[i].a, got_wr[i].d, exp_wr[i].t, exp_wr[i].a, exp_wr[i].d);
                end
            end
            total++;
            if (got_done != exp_done || got_err !== exp_err || got_rom_end !== exp_rom_end) begin
                bad++;
                $display("FAIL rand%0d_end: got done=%0d err=%b rom=%h want done=%0d err=%b rom=%h", n,
                         got_done, got_err, got_rom_end, exp_done, exp_err, exp_rom_end);
            end
            total++;
            if (got_err0 !== 1'b0 || got_busy0 !== 1'b1 || got_done_after !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d_flags: got err0=%b busy0=%b done_after=%b want 0 1 0", n,
                         got_err0, got_busy0, got_done_after);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        test_basic();
        test_overrun();
        test_reset();
        test_transparent();
        test_abort();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
